fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_pkg.sv | 35 +++
 rtl/fwd_stage_entry.sv | 63 ++++++
 rtl/fwd_scoreboard.sv | 113 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg -- shared definitions for the forwarding scoreboard.
//   FWD_SEL_RF      : forward-select value meaning "read the register file"
//   LAT_ALU/LAT_LOAD: result latencies of the two instruction classes
//   fwd_entry_t     : one in-flight stage entry {valid, rd, cnt}, sized for
//                     the widest register address / counter the block supports
//   clamp_lat()     : maps a raw issue latency onto 1..depth
package fwd_pkg;

    localparam int unsigned FWD_SEL_RF    = 0;
    localparam int unsigned LAT_ALU       = 1;
    localparam int unsigned LAT_LOAD      = 2;

    // Upper bounds for the entry fields; REG_AW and SEL_W of an instance
    // must not exceed these.
    localparam int unsigned FWD_AW_MAX    = 8;
    localparam int unsigned FWD_CNT_MAX_W = 8;

    typedef struct packed {
        logic                     valid;
        logic [FWD_AW_MAX-1:0]    rd;
        logic [FWD_CNT_MAX_W-1:0] cnt;
    } fwd_entry_t;

    // A latency of 0 behaves like an ALU op; anything beyond the tracked
    // depth is as late as the pipeline can express.
    function automatic int unsigned clamp_lat(input int unsigned lat,
                                              input int unsigned depth);
        if (lat == 0)
            return LAT_ALU;
        if (lat > depth)
            return depth;
        return lat;
    endfunction

endpackage

// File: rtl/fwd_stage_entry.sv
// fwd_stage_entry -- one in-flight stage of the forwarding scoreboard.
//   clk, rst        : clock, asynchronous active-high reset
//   hold            : freeze contents
//   clear           : invalidate the entry (wins over hold)
//   in_valid/rd/cnt : entry arriving from the previous stage (or issue)
//   valid_o/rd_o/cnt_o : current contents
// With DEC_ON_LOAD set, the incoming counter is decremented (saturating at 0)
// as it is captured, so the countdown follows the entry down the pipeline.
module fwd_stage_entry #(
    parameter int unsigned AW          = 5,
    parameter int unsigned CW          = 2,
    parameter bit          DEC_ON_LOAD = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [AW-1:0] in_rd,
    input  logic [CW-1:0] in_cnt,
    output logic          valid_o,
    output logic [AW-1:0] rd_o,
    output logic [CW-1:0] cnt_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (clear) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (!hold) begin
            valid_d = in_valid;
            rd_d    = in_rd;
            if (DEC_ON_LOAD && (in_cnt != '0))
                cnt_d = in_cnt - CW'(1);
            else
                cnt_d = in_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard -- operand forwarding select and load-use stall generation.
//   clk, rst     : clock, asynchronous active-high reset
//   iss_*        : instruction presented for issue (sources, dest, latency)
//   hold         : freeze the whole pipeline
//   flush        : drop the issuing instruction and the stage-1 entry
//   fwd_sel      : per source, 0 = register file, k = forward from stage k
//   stall        : issuing instruction must not advance
// Stage 1 is the youngest in-flight result. Each source picks its nearest
// matching stage; if that entry's result is not yet available the issue
// stalls, even when an older, ready entry for the same register exists.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  iss_rs,
    input  logic [NUM_SRC-1:0]         iss_rs_used,
    input  logic [REG_AW-1:0]          iss_rd,
    input  logic                       iss_regwrite,
    input  logic [SEL_W-1:0]           iss_lat,
    input  logic                       hold,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall
);

    logic              stg_in_valid [1:FWD_DEPTH];
    logic [REG_AW-1:0] stg_in_rd    [1:FWD_DEPTH];
    logic [SEL_W-1:0]  stg_in_cnt   [1:FWD_DEPTH];
    logic              stg_valid    [1:FWD_DEPTH];
    logic [REG_AW-1:0] stg_rd       [1:FWD_DEPTH];
    logic [SEL_W-1:0]  stg_cnt      [1:FWD_DEPTH];
    fwd_entry_t        ent          [1:FWD_DEPTH];
    logic [NUM_SRC-1:0] src_block;

    logic issue_writes;
    assign issue_writes = iss_valid && !stall && !flush && iss_regwrite
                          && (iss_rd != '0);

    genvar gi;
    generate
        for (gi = 1; gi <= FWD_DEPTH; gi++) begin : g_stage
            if (gi == 1) begin : g_head
                // Issue captures lat-1 directly: a latency-1 result is
                // forwardable from stage 1 on the very next cycle.
                assign stg_in_valid[gi] = issue_writes;
                assign stg_in_rd[gi]    = iss_rd;
                assign stg_in_cnt[gi]   =
                    SEL_W'(clamp_lat(int'(iss_lat), FWD_DEPTH) - 1);
            end else begin : g_tail
                // A flush also kills the entry leaving stage 1.
                assign stg_in_valid[gi] = stg_valid[gi-1] && !((gi == 2) && flush);
                assign stg_in_rd[gi]    = stg_rd[gi-1];
                assign stg_in_cnt[gi]   = stg_cnt[gi-1];
            end

            fwd_stage_entry #(
                .AW          (REG_AW),
                .CW          (SEL_W),
                .DEC_ON_LOAD (gi != 1)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .hold     (hold),
                .clear    ((gi == 1) && flush),
                .in_valid (stg_in_valid[gi]),
                .in_rd    (stg_in_rd[gi]),
                .in_cnt   (stg_in_cnt[gi]),
                .valid_o  (stg_valid[gi]),
                .rd_o     (stg_rd[gi]),
                .cnt_o    (stg_cnt[gi])
            );

            assign ent[gi] = '{valid: stg_valid[gi],
                               rd:    FWD_AW_MAX'(stg_rd[gi]),
                               cnt:   FWD_CNT_MAX_W'(stg_cnt[gi])};
        end

        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] rs;
            logic [SEL_W-1:0]  sel;
            logic              hit_ready;

            assign rs = iss_rs[gi*REG_AW +: REG_AW];

            // Scan oldest to youngest so the nearest match is left standing.
            always_comb begin
                sel       = SEL_W'(FWD_SEL_RF);
                hit_ready = 1'b1;
                if (iss_rs_used[gi] && (rs != '0)) begin
                    for (int k = FWD_DEPTH; k >= 1; k--) begin
                        if (ent[k].valid && (ent[k].rd == FWD_AW_MAX'(rs))) begin
                            sel       = SEL_W'(k);
                            hit_ready = (ent[k].cnt == '0);
                        end
                    end
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
            assign src_block[gi]              = !hit_ready;
        end
    endgenerate

    assign stall = iss_valid && (|src_block);

endmodule
